div_issue_hilo: RTL and testbench

- EX-stage control block that sits directly upstream of the iterative 32-bit divider.
- Accepts DIV/DIVU and MTHI/MTLO requests from the EX stage and launches one divide at a time with a single-cycle request pulse.
- Waits for the divider's completion flag, then commits the quotient to LO and the remainder to HI.
- Stalls the pipeline while any HI/LO access conflicts with an in-flight divide; a flush mid-divide drains the divider without committing.

---
 rtl/div_issue_hilo_pkg.sv | 29 ++
 rtl/div_issue_hilo_hilo_regs.sv | 36 +++
 rtl/div_issue_hilo.sv | 143 ++++++++++++++
 tb/tb_div_issue_hilo.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_issue_hilo_pkg.sv
// Shared types and constants for the divide issue / HI-LO control slice.
// The divider datapath is fixed at 32 bits.
package div_issue_hilo_pkg;

  localparam int DIV_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Divide-by-zero result: LO is all ones, HI takes the dividend.
  localparam logic [DIV_DW-1:0] DZ_LO = {DIV_DW{1'b1}};

  // Combined HI/LO write from a divide commit.
  typedef struct packed {
    logic              we;
    logic [DIV_DW-1:0] hi;
    logic [DIV_DW-1:0] lo;
  } hilo_wr_t;

  function automatic logic is_hilo_op(input logic div, input logic mthi,
                                      input logic mtlo, input logic rd);
    return div | mthi | mtlo | rd;
  endfunction

endpackage

// File: rtl/div_issue_hilo_hilo_regs.sv
// HI and LO architectural registers. A divide commit overrides any
// simultaneous MTHI/MTLO write.
module div_issue_hilo_hilo_regs
  import div_issue_hilo_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_resetn,
  input  hilo_wr_t          i_cm,
  input  logic              i_mthi_we,
  input  logic              i_mtlo_we,
  input  logic [DIV_DW-1:0] i_mt_data,
  output logic [DIV_DW-1:0] o_hi,
  output logic [DIV_DW-1:0] o_lo
);

  logic [DIV_DW-1:0] r_hi;
  logic [DIV_DW-1:0] r_lo;

  // HI/LO update with commit priority
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_hi <= {DIV_DW{1'b0}};
      r_lo <= {DIV_DW{1'b0}};
    end else if (i_cm.we) begin
      r_hi <= i_cm.hi;
      r_lo <= i_cm.lo;
    end else begin
      if (i_mthi_we) r_hi <= i_mt_data;
      if (i_mtlo_we) r_lo <= i_mt_data;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/div_issue_hilo.sv
// EX-stage divide launcher and HI/LO owner: issues one divide at a time,
// commits on the divider's completion flag, and drains on flush.
module div_issue_hilo
  import div_issue_hilo_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic          div_clk,
  input  logic          resetn,
  input  logic          op_valid,
  input  logic          op_div,
  input  logic          op_signed,
  input  logic          op_mthi,
  input  logic          op_mtlo,
  input  logic          op_hilo_rd,
  input  logic [DW-1:0] op_x,
  input  logic [DW-1:0] op_y,
  input  logic          flush,
  output logic          dv_req,
  output logic          dv_signed,
  output logic [DW-1:0] dv_x,
  output logic [DW-1:0] dv_y,
  input  logic [DW-1:0] dv_s,
  input  logic [DW-1:0] dv_r,
  input  logic          dv_complete,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo,
  output logic          busy,
  output logic          stall,
  output logic          done
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_dv_req;
  logic          r_dv_signed;
  logic [DW-1:0] r_dv_x;
  logic [DW-1:0] r_dv_y;
  logic          r_busy;
  logic          r_done;

  logic          w_idle;
  logic          w_div_go;
  logic          w_mthi_we;
  logic          w_mtlo_we;
  hilo_wr_t      w_cm;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_div_go = w_idle & op_valid & op_div & (op_y != {DW{1'b0}});

  // Next state, divide commit and MTxx write enables
  always_comb begin
    w_state_nxt = r_state;
    w_cm.we     = 1'b0;
    w_cm.hi     = dv_r;
    w_cm.lo     = dv_s;
    w_mthi_we   = 1'b0;
    w_mtlo_we   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (op_valid & op_div) begin
          if (op_y != {DW{1'b0}}) begin
            w_state_nxt = ST_ISSUE;
          end else begin
            w_cm.we = 1'b1;
            w_cm.hi = op_x;
            w_cm.lo = DZ_LO;
          end
        end else if (op_valid & op_mthi) begin
          w_mthi_we = 1'b1;
        end else if (op_valid & op_mtlo) begin
          w_mtlo_we = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (flush) w_state_nxt = ST_DRAIN;
        else       w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion arriving with flush still commits.
        if (dv_complete) begin
          w_cm.we     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (flush) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (dv_complete) w_state_nxt = ST_IDLE;
        else             w_state_nxt = ST_DRAIN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, divider request/operands and status outputs
  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_dv_req    <= 1'b0;
      r_dv_signed <= 1'b0;
      r_dv_x      <= {DW{1'b0}};
      r_dv_y      <= {DW{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dv_req <= (w_state_nxt == ST_ISSUE);
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_done   <= w_cm.we;
      if (w_div_go) begin
        r_dv_x      <= op_x;
        r_dv_y      <= op_y;
        r_dv_signed <= op_signed;
      end
    end
  end

  div_issue_hilo_hilo_regs u_hilo (
    .i_clk     (div_clk),
    .i_resetn  (resetn),
    .i_cm      (w_cm),
    .i_mthi_we (w_mthi_we),
    .i_mtlo_we (w_mtlo_we),
    .i_mt_data (op_x),
    .o_hi      (hi),
    .o_lo      (lo)
  );

  assign dv_req    = r_dv_req;
  assign dv_signed = r_dv_signed;
  assign dv_x      = r_dv_x;
  assign dv_y      = r_dv_y;
  assign busy      = r_busy;
  assign done      = r_done;
  assign stall     = (r_busy & op_valid & is_hilo_op(op_div, op_mthi, op_mtlo, op_hilo_rd))
                   | w_div_go;

endmodule

// File: tb/tb_div_issue_hilo.sv
// Directed bench for div_issue_hilo with a behavioural iterative-divider model.
module tb_div_issue_hilo;

  localparam int LAT = 35;

  logic        div_clk = 1'b0;
  logic        resetn;
  logic        op_valid, op_div, op_signed, op_mthi, op_mtlo, op_hilo_rd;
  logic [31:0] op_x, op_y;
  logic        flush;
  logic        dv_req, dv_signed;
  logic [31:0] dv_x, dv_y, dv_s, dv_r;
  logic        dv_complete;
  logic [31:0] hi, lo;
  logic        busy, stall, done;

  logic [31:0] m_s, m_r;
  int          m_cnt;
  logic        m_cmp;
  logic        inj_cmp;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] e_lo;
    logic [31:0] e_hi;
    string       name;
  } vec_t;

  vec_t vt[6];

  always #5 div_clk = ~div_clk;

  div_issue_hilo #(.DW(32)) dut (
    .div_clk(div_clk), .resetn(resetn), .op_valid(op_valid), .op_div(op_div),
    .op_signed(op_signed), .op_mthi(op_mthi), .op_mtlo(op_mtlo),
    .op_hilo_rd(op_hilo_rd), .op_x(op_x), .op_y(op_y), .flush(flush),
    .dv_req(dv_req), .dv_signed(dv_signed), .dv_x(dv_x), .dv_y(dv_y),
    .dv_s(dv_s), .dv_r(dv_r), .dv_complete(dv_complete),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  // Iterative divider stand-in: samples on dv_req, pulses complete LAT edges later
  always @(posedge div_clk) begin
    if (!resetn) begin
      m_cnt <= 0;
      m_cmp <= 1'b0;
    end else if (dv_req) begin
      m_cnt <= LAT;
      m_cmp <= 1'b0;
      if (dv_signed) begin
        m_s <= $signed(dv_x) / $signed(dv_y);
        m_r <= $signed(dv_x) % $signed(dv_y);
      end else begin
        m_s <= dv_x / dv_y;
        m_r <= dv_x % dv_y;
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      m_cmp <= (m_cnt == 1);
    end else begin
      m_cmp <= 1'b0;
    end
  end

  assign dv_s        = m_s;
  assign dv_r        = m_r;
  assign dv_complete = m_cmp | inj_cmp;

  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic clear_ops();
    op_valid = 1'b0; op_div = 1'b0; op_signed = 1'b0; op_mthi = 1'b0;
    op_mtlo = 1'b0; op_hilo_rd = 1'b0; op_x = 32'd0; op_y = 32'd0;
  endtask

  // Present a DIV for one edge; on return the DUT is in ISSUE (or has committed y==0)
  task automatic launch(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    op_valid = 1'b1; op_div = 1'b1; op_signed = sgn; op_x = x; op_y = y;
    tick();
    clear_ops();
  endtask

  task automatic wait_idle(input string nm, output int dones);
    bit ok;
    ok = 1'b0;
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done) dones++;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk1({nm, "_idle_in_time"}, ok, 1'b1);
  endtask

  task automatic run_div(input vec_t v);
    int  reqs, dones, stall_bad;
    bit  seen;
    logic last_cmp;
    logic nz;
    nz = (v.y != 32'd0);
    op_valid = 1'b1; op_div = 1'b1; op_signed = v.sgn; op_x = v.x; op_y = v.y;
    #1;
    chk1({v.name, "_stall_launch"}, stall, nz);
    tick();
    clear_ops();
    reqs = 0; dones = 0; stall_bad = 0; seen = 1'b0; last_cmp = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (dv_req) reqs++;
      if (done) begin
        dones++;
        seen = 1'b1;
      end else begin
        last_cmp = dv_complete;
        op_valid = 1'b1; op_hilo_rd = 1'b1;
        #1;
        if (stall !== 1'b1) stall_bad++;
        tick();
      end
    end
    chk1({v.name, "_done_seen"}, seen, 1'b1);
    chk32({v.name, "_dv_req_cycles"}, reqs, nz ? 32'd1 : 32'd0);
    chk32({v.name, "_lo"}, lo, v.e_lo);
    chk32({v.name, "_hi"}, hi, v.e_hi);
    chk1({v.name, "_busy_after"}, busy, 1'b0);
    chk1({v.name, "_mfhi_stall_at_commit"}, stall, 1'b0);
    chk32({v.name, "_mfhi_stall_held"}, stall_bad, 32'd0);
    if (nz) chk1({v.name, "_complete_before_commit"}, last_cmp, 1'b1);
    clear_ops();
    tick();
    chk1({v.name, "_done_single"}, done, 1'b0);
    chk1({v.name, "_no_extra_req"}, dv_req, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int          dn;
    bit          ok;
    logic [31:0] h0, l0;

    vt[0] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2"};
    vt[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, "divu_ff_16"};
    vt[2] = '{1'b1, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_1234, "div_by_zero"};
    vt[3] = '{1'b1, 32'd100,       32'd7,         32'h0000_000E, 32'h0000_0002, "div_100_7"};
    vt[4] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, "div_7_m2"};
    vt[5] = '{1'b0, 32'h8000_0000, 32'd3,         32'h2AAA_AAAA, 32'h0000_0002, "divu_min_3"};

    clear_ops();
    flush = 1'b0; inj_cmp = 1'b0; resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    chk32("rst_hi", hi, 32'd0);
    chk32("rst_lo", lo, 32'd0);
    chk32("rst_dv_x", dv_x, 32'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_dv_req", dv_req, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_stall", stall, 1'b0);

    op_valid = 1'b1; op_mthi = 1'b1; op_x = 32'h1111_2222;
    tick();
    clear_ops();
    chk32("mthi_hi", hi, 32'h1111_2222);
    op_valid = 1'b1; op_mtlo = 1'b1; op_x = 32'h3333_4444;
    tick();
    clear_ops();
    chk32("mtlo_lo", lo, 32'h3333_4444);
    op_valid = 1'b1; op_mthi = 1'b1; op_mtlo = 1'b1; op_x = 32'h5555_6666;
    tick();
    clear_ops();
    chk32("mt_both_hi", hi, 32'h5555_6666);
    chk32("mt_both_lo_kept", lo, 32'h3333_4444);

    // Stray completion flag in IDLE must be ignored
    inj_cmp = 1'b1;
    tick();
    inj_cmp = 1'b0;
    chk1("idle_cmp_done", done, 1'b0);
    chk32("idle_cmp_hi", hi, 32'h5555_6666);
    chk1("idle_cmp_busy", busy, 1'b0);

    for (int i = 0; i < 6; i++) run_div(vt[i]);

    // MFHI three cycles after DIV; unrelated op not stalled
    launch(1'b0, 32'd1000, 32'd10);
    tick(); tick();
    op_valid = 1'b1;
    #1;
    chk1("nonhilo_not_stalled", stall, 1'b0);
    op_hilo_rd = 1'b1;
    #1;
    chk1("mfhi_stalled", stall, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk1("mfhi_commit_seen", ok, 1'b1);
    chk1("mfhi_released", stall, 1'b0);
    chk32("mfhi_lo", lo, 32'd100);
    chk32("mfhi_hi", hi, 32'd0);
    clear_ops();
    tick();

    // Flush five cycles into WAIT: drain without commit
    h0 = hi; l0 = lo;
    launch(1'b1, 32'd100, 32'd7);
    tick();
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("flush_busy_drain", busy, 1'b1);
    op_valid = 1'b1; op_mthi = 1'b1; op_x = 32'hDEAD_BEEF;
    #1;
    chk1("drain_mthi_stall", stall, 1'b1);
    clear_ops();
    wait_idle("flush_wait", dn);
    chk32("flush_no_done", dn, 32'd0);
    chk32("flush_hi_kept", hi, h0);
    chk32("flush_lo_kept", lo, l0);
    run_div(vt[0]);

    // Flush coinciding with completion: commit wins
    launch(1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (dv_complete) begin
        ok = 1'b1;
        break;
      end
    end
    chk1("flushcmp_seen", ok, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("flushcmp_done", done, 1'b1);
    chk32("flushcmp_lo", lo, 32'h0FFF_FFFF);
    chk32("flushcmp_hi", hi, 32'h0000_000F);
    chk1("flushcmp_busy", busy, 1'b0);

    // Flush while in ISSUE
    h0 = hi; l0 = lo;
    launch(1'b1, 32'd100, 32'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("issue_flush_busy", busy, 1'b1);
    wait_idle("issue_flush", dn);
    chk32("issue_flush_no_done", dn, 32'd0);
    chk32("issue_flush_lo_kept", lo, l0);

    // Reset during WAIT, then MTLO
    launch(1'b1, 32'd100, 32'd7);
    tick(); tick(); tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk1("midrst_busy", busy, 1'b0);
    chk32("midrst_hi", hi, 32'd0);
    chk32("midrst_lo", lo, 32'd0);
    chk1("midrst_dv_req", dv_req, 1'b0);
    op_valid = 1'b1; op_mtlo = 1'b1; op_x = 32'hA5A5_A5A5;
    tick();
    clear_ops();
    chk32("post_rst_mtlo", lo, 32'hA5A5_A5A5);
    run_div(vt[3]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
